// File: rtl/i2c_regfile_arb_pkg.sv
// Shared definitions for the I2C register-file arbiter.
//   BYTE_W  : data width of the register file and all byte paths
//   gnt_e   : which requester owns the RAM port in the current cycle
//   state_e : arbiter FSM states
package i2c_regfile_arb_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_I2CW = 2'd1,
        GNT_PF   = 2'd2,
        GNT_HOST = 2'd3
    } gnt_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PF_WAIT  = 2'd1,   // prefetch data returning from RAM
        ST_HRD_WAIT = 2'd2,   // host read data returning from RAM
        ST_HACK     = 2'd3    // host_ack presented this cycle
    } state_e;

endpackage

// File: rtl/i2c_regfile_arb_if.sv
// Local host bus into the register-file arbiter.
//   master : host side (drives req/we/addr/wdat, receives ack/rdat)
//   slave  : arbiter side
// host_req is held until host_ack; we/addr/wdat are stable while requesting.
interface i2c_regfile_arb_if
    import i2c_regfile_arb_pkg::*;
#(
    parameter int LD_NBYTES = 3
) ();

    logic                 host_req;
    logic                 host_we;
    logic [LD_NBYTES-1:0] host_addr;
    logic [BYTE_W-1:0]    host_wdat;
    logic                 host_ack;
    logic [BYTE_W-1:0]    host_rdat;

    modport master (
        output host_req, host_we, host_addr, host_wdat,
        input  host_ack, host_rdat
    );

    modport slave (
        input  host_req, host_we, host_addr, host_wdat,
        output host_ack, host_rdat
    );

endinterface

// File: rtl/i2c_regfile_arb_ptr_ctl.sv
// I2C strobe decoder: owns the auto-increment index pointer, the
// "first write after addressing sets the index" flag and the pending
// write/prefetch requests toward the arbiter.
//   clk, rst            : clock, synchronous active-high reset
//   i2c_as/rs/ws        : slave strobes (priority as > ws > rs)
//   i2c_wdat            : byte received with i2c_ws
//   wr_gnt, pf_gnt      : arbiter accepted the pending write / prefetch
//   host_hit            : host write granted at the current pointer
//   ptr                 : current index
//   wr_pend/addr/data   : latched I2C write awaiting the RAM port
//   pf_pend             : cached byte at ptr must be (re)fetched
//   ptr_chg             : a ws/rs strobe was accepted this cycle
module i2c_regfile_arb_ptr_ctl
    import i2c_regfile_arb_pkg::*;
#(
    parameter int LD_NBYTES = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i2c_as,
    input  logic                 i2c_rs,
    input  logic                 i2c_ws,
    input  logic [BYTE_W-1:0]    i2c_wdat,
    input  logic                 wr_gnt,
    input  logic                 pf_gnt,
    input  logic                 host_hit,
    output logic [LD_NBYTES-1:0] ptr,
    output logic                 wr_pend,
    output logic [LD_NBYTES-1:0] wr_addr,
    output logic [BYTE_W-1:0]    wr_data,
    output logic                 pf_pend,
    output logic                 ptr_chg
);

    logic [LD_NBYTES-1:0] ptr_q;
    logic                 as_seen_q;
    logic                 wr_pend_q;
    logic [LD_NBYTES-1:0] wr_addr_q;
    logic [BYTE_W-1:0]    wr_data_q;
    logic                 pf_pend_q;

    // An address match masks any coincident ws/rs.
    assign ptr_chg = !i2c_as && (i2c_ws || i2c_rs);

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q     <= '0;
            as_seen_q <= 1'b0;
            wr_pend_q <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            pf_pend_q <= 1'b1;   // fetch mem[0] right after reset
        end else begin
            // Grants retire requests; a new request in the same cycle wins.
            wr_pend_q <= wr_pend_q && !wr_gnt;
            pf_pend_q <= (pf_pend_q && !pf_gnt) || host_hit;

            if (i2c_as) begin
                as_seen_q <= 1'b1;
            end else if (i2c_ws) begin
                pf_pend_q <= 1'b1;
                if (as_seen_q) begin
                    ptr_q     <= i2c_wdat[LD_NBYTES-1:0];
                    as_seen_q <= 1'b0;
                end else begin
                    wr_pend_q <= 1'b1;
                    wr_addr_q <= ptr_q;
                    wr_data_q <= i2c_wdat;
                    ptr_q     <= ptr_q + LD_NBYTES'(1);
                end
            end else if (i2c_rs) begin
                as_seen_q <= 1'b0;
                ptr_q     <= ptr_q + LD_NBYTES'(1);
                pf_pend_q <= 1'b1;
            end
        end
    end

    assign ptr     = ptr_q;
    assign wr_pend = wr_pend_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign pf_pend = pf_pend_q;

endmodule

// File: rtl/i2c_regfile_arb.sv
// Register-file controller/arbiter behind an I2C slave. One external
// single-port RAM (1-cycle read latency) is shared between I2C writes,
// the prefetch of the byte at the I2C pointer, and a local host bus.
//   clk, rst            : clock, synchronous active-high reset
//   i2c_as/rs/ws/wdat   : slave strobes and received byte
//   i2c_rdat(_vld)      : prefetched byte at ptr for the slave's dat_in
//   host                : host bus (slave modport)
//   mem_*               : RAM port
//   ptr                 : current I2C index (debug)
// Fixed RAM priority: I2C write > prefetch > host.
module i2c_regfile_arb
    import i2c_regfile_arb_pkg::*;
#(
    parameter int LD_NBYTES = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i2c_as,
    input  logic                 i2c_rs,
    input  logic                 i2c_ws,
    input  logic [BYTE_W-1:0]    i2c_wdat,
    output logic [BYTE_W-1:0]    i2c_rdat,
    output logic                 i2c_rdat_vld,
    i2c_regfile_arb_if.slave     host,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [LD_NBYTES-1:0] mem_addr,
    output logic [BYTE_W-1:0]    mem_wdat,
    input  logic [BYTE_W-1:0]    mem_rdat,
    output logic [LD_NBYTES-1:0] ptr
);

    state_e               state_q;
    gnt_e                 gnt;
    logic                 pf_ok_q;
    logic [BYTE_W-1:0]    rdat_q;
    logic                 rdat_vld_q;
    logic [BYTE_W-1:0]    host_rdat_q;

    logic                 wr_pend;
    logic [LD_NBYTES-1:0] wr_addr;
    logic [BYTE_W-1:0]    wr_data;
    logic                 pf_pend;
    logic                 ptr_chg;
    logic                 host_hit;
    logic                 inval;

    i2c_regfile_arb_ptr_ctl #(
        .LD_NBYTES (LD_NBYTES)
    ) u_ptr_ctl (
        .clk      (clk),
        .rst      (rst),
        .i2c_as   (i2c_as),
        .i2c_rs   (i2c_rs),
        .i2c_ws   (i2c_ws),
        .i2c_wdat (i2c_wdat),
        .wr_gnt   (gnt == GNT_I2CW),
        .pf_gnt   (gnt == GNT_PF),
        .host_hit (host_hit),
        .ptr      (ptr),
        .wr_pend  (wr_pend),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .pf_pend  (pf_pend),
        .ptr_chg  (ptr_chg)
    );

    // Grant from registered flags. A ws/rs arriving this cycle will raise
    // pending I2C work next cycle, so the host is held off to let that
    // work go first. The host is not re-sampled while its own access is
    // still completing (HRD_WAIT/HACK).
    always_comb begin
        gnt = GNT_NONE;
        if (!rst && state_q != ST_HRD_WAIT) begin
            if (wr_pend) begin
                gnt = GNT_I2CW;
            end else if (pf_pend) begin
                gnt = GNT_PF;
            end else if (host.host_req && state_q != ST_HACK &&
                         !i2c_ws && !i2c_rs) begin
                gnt = GNT_HOST;
            end
        end
    end

    assign host_hit = (gnt == GNT_HOST) && host.host_we && (host.host_addr == ptr);
    // Anything that makes the cached byte stale.
    assign inval    = ptr_chg || host_hit;

    always_comb begin
        mem_en   = (gnt != GNT_NONE);
        mem_we   = (gnt == GNT_I2CW) || ((gnt == GNT_HOST) && host.host_we);
        mem_addr = '0;
        mem_wdat = '0;
        case (gnt)
            GNT_I2CW: begin
                mem_addr = wr_addr;
                mem_wdat = wr_data;
            end
            GNT_PF: begin
                mem_addr = ptr;
            end
            GNT_HOST: begin
                mem_addr = host.host_addr;
                mem_wdat = host.host_wdat;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            pf_ok_q     <= 1'b0;
            rdat_q      <= '0;
            rdat_vld_q  <= 1'b0;
            host_rdat_q <= '0;
        end else begin
            case (gnt)
                GNT_PF: begin
                    state_q <= ST_PF_WAIT;
                    // A strobe in the grant cycle already moved ptr.
                    pf_ok_q <= !inval;
                end
                GNT_HOST: begin
                    state_q <= host.host_we ? ST_HACK : ST_HRD_WAIT;
                end
                default: begin
                    state_q <= (state_q == ST_HRD_WAIT) ? ST_HACK : ST_IDLE;
                end
            endcase

            if (state_q == ST_HRD_WAIT) begin
                host_rdat_q <= mem_rdat;
            end

            // Returned prefetch data is only trusted if nothing disturbed
            // the pointer or the addressed byte in either cycle.
            if (inval) begin
                rdat_vld_q <= 1'b0;
            end else if (state_q == ST_PF_WAIT && pf_ok_q) begin
                rdat_q     <= mem_rdat;
                rdat_vld_q <= 1'b1;
            end
        end
    end

    assign i2c_rdat       = rdat_q;
    assign i2c_rdat_vld   = rdat_vld_q;
    assign host.host_ack  = (state_q == ST_HACK);
    assign host.host_rdat = host_rdat_q;

endmodule

// File: tb/tb_i2c_regfile_arb.sv
module tb_i2c_regfile_arb;

    localparam int LDN = 3;

    typedef struct {
        logic       we;
        logic [7:0] data;
    } hexp_t;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           i2c_as = 1'b0;
    logic           i2c_rs = 1'b0;
    logic           i2c_ws = 1'b0;
    logic [7:0]     i2c_wdat = 8'h00;
    logic [7:0]     i2c_rdat;
    logic           i2c_rdat_vld;
    logic           mem_en;
    logic           mem_we;
    logic [LDN-1:0] mem_addr;
    logic [7:0]     mem_wdat;
    logic [7:0]     mem_rdat = 8'h00;
    logic [LDN-1:0] ptr;

    i2c_regfile_arb_if #(.LD_NBYTES(LDN)) hbus ();

    i2c_regfile_arb #(.LD_NBYTES(LDN)) dut (
        .clk          (clk),
        .rst          (rst),
        .i2c_as       (i2c_as),
        .i2c_rs       (i2c_rs),
        .i2c_ws       (i2c_ws),
        .i2c_wdat     (i2c_wdat),
        .i2c_rdat     (i2c_rdat),
        .i2c_rdat_vld (i2c_rdat_vld),
        .host         (hbus),
        .mem_en       (mem_en),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdat     (mem_wdat),
        .mem_rdat     (mem_rdat),
        .ptr          (ptr)
    );

    always #5 clk = ~clk;

    // External RAM and the bench's own hand-maintained expectation of it.
    logic [7:0] ram     [8] = '{8'hA5, 8'hB1, 8'hC2, 8'h3C, 8'h44, 8'h55, 8'h66, 8'h77};
    logic [7:0] exp_mem [8] = '{8'hA5, 8'hB1, 8'hC2, 8'h3C, 8'h44, 8'h55, 8'h66, 8'h77};

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdat;
            else        mem_rdat      <= ram[mem_addr];
        end
    end

    int n_chk = 0;
    int n_pass = 0;
    hexp_t hq[$];

    int cyc = 0;
    int wr_cnt = 0;
    int last_wr_cyc = 0;
    int grant_cyc = 0;
    int ack_cnt = 0;
    int ack_cyc = 0;
    int vld_rise_cyc = 0;
    logic vld_at_ack = 1'b0;
    logic vld_prev = 1'b0;
    logic [LDN-1:0] watch_addr = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Monitor / scoreboard: samples on the falling edge.
    always @(negedge clk) begin
        hexp_t e;
        cyc++;
        if (mem_en && mem_we) begin
            wr_cnt++;
            last_wr_cyc = cyc;
        end
        if (mem_en && !mem_we && mem_addr == watch_addr) grant_cyc = cyc;
        if (i2c_rdat_vld && !vld_prev) begin
            vld_rise_cyc = cyc;
            $display("prefetch ptr=%0d data=%02h", ptr, i2c_rdat);
            check("prefetch_byte", {24'd0, i2c_rdat}, {24'd0, exp_mem[ptr]});
        end
        vld_prev = i2c_rdat_vld;
        if (hbus.host_ack) begin
            ack_cnt++;
            ack_cyc = cyc;
            vld_at_ack = i2c_rdat_vld;
            check("host_ack_expected", {31'd0, hq.size() != 0}, 32'd1);
            if (hq.size() != 0) begin
                e = hq.pop_front();
                $display("host ack we=%0b rdat=%02h", e.we, hbus.host_rdat);
                if (!e.we) check("host_rdat", {24'd0, hbus.host_rdat}, {24'd0, e.data});
            end
        end
    end

    task automatic strobe(input bit a, input bit w, input bit r, input logic [7:0] d);
        @(posedge clk); #1;
        i2c_as = a; i2c_ws = w; i2c_rs = r; i2c_wdat = d;
        $display("strobe as=%0b ws=%0b rs=%0b wdat=%02h ptr=%0d", a, w, r, d, ptr);
        @(posedge clk); #1;
        i2c_as = 1'b0; i2c_ws = 1'b0; i2c_rs = 1'b0;
        repeat (7) @(posedge clk);
        #1;
    endtask

    task automatic wait_vld(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (i2c_rdat_vld) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Host access, optionally with a coincident I2C write strobe.
    task automatic host_op(input bit we, input logic [LDN-1:0] addr, input logic [7:0] wd,
                           input logic [7:0] exp_rd, input bit with_ws,
                           input logic [7:0] ws_dat, output int lat);
        int a0, start;
        bit got;
        @(posedge clk); #1;
        hq.push_back('{we, exp_rd});
        a0 = ack_cnt;
        start = cyc;
        hbus.host_req = 1'b1; hbus.host_we = we; hbus.host_addr = addr; hbus.host_wdat = wd;
        if (with_ws) begin
            i2c_ws = 1'b1; i2c_wdat = ws_dat;
        end
        got = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            i2c_ws = 1'b0;
            if (ack_cnt > a0) begin
                got = 1'b1;
                break;
            end
        end
        hbus.host_req = 1'b0;
        check("host_ack_seen", {31'd0, got}, 32'd1);
        lat = ack_cyc - start;
    endtask

    initial begin
        int  lat_u, lat_c, a0, w0;
        bit  ok, found;
        hbus.host_req = 1'b0; hbus.host_we = 1'b0; hbus.host_addr = '0; hbus.host_wdat = 8'h00;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ptr", {29'd0, ptr}, 32'd0);
        check("rst_vld", {31'd0, i2c_rdat_vld}, 32'd0);
        check("rst_ack", {31'd0, hbus.host_ack}, 32'd0);
        check("rst_mem_en", {31'd0, mem_en}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        wait_vld(3, ok);
        check("boot_vld", {31'd0, ok}, 32'd1);
        check("boot_rdat", {24'd0, i2c_rdat}, 32'hA5);
        check("boot_ptr", {29'd0, ptr}, 32'd0);

        // Index set then two auto-incrementing writes.
        strobe(1'b1, 1'b0, 1'b0, 8'h00);
        strobe(1'b0, 1'b1, 1'b0, 8'h05);
        exp_mem[5] = 8'h11;
        strobe(1'b0, 1'b1, 1'b0, 8'h11);
        exp_mem[6] = 8'h22;
        strobe(1'b0, 1'b1, 1'b0, 8'h22);
        @(negedge clk);
        check("ram5", {24'd0, ram[5]}, 32'h11);
        check("ram6", {24'd0, ram[6]}, 32'h22);
        check("ptr_after_wr", {29'd0, ptr}, 32'd7);

        // Reads wrap 7 -> 0 -> 1.
        strobe(1'b0, 1'b0, 1'b1, 8'h00);
        @(negedge clk);
        check("wrap_ptr", {29'd0, ptr}, 32'd0);
        check("wrap_rdat", {24'd0, i2c_rdat}, 32'hA5);
        check("wrap_vld", {31'd0, i2c_rdat_vld}, 32'd1);
        strobe(1'b0, 1'b0, 1'b1, 8'h00);
        @(negedge clk);
        check("ptr_after_rs", {29'd0, ptr}, 32'd1);

        // Uncontended host read, then one contended with an I2C write.
        host_op(1'b0, 3'd4, 8'h00, 8'h44, 1'b0, 8'h00, lat_u);
        repeat (4) @(posedge clk);
        #1;
        watch_addr = 3'd3;
        exp_mem[1] = 8'h33;
        a0 = ack_cnt;
        host_op(1'b0, 3'd3, 8'h00, 8'h3C, 1'b1, 8'h33, lat_c);
        repeat (6) @(posedge clk);
        #1;
        check("contend_ack_once", ack_cnt - a0, 32'd1);
        check("contend_wr_first", {31'd0, last_wr_cyc < grant_cyc}, 32'd1);
        check("contend_ack_gnt2", ack_cyc - grant_cyc, 32'd2);
        check("contend_slower", {31'd0, lat_c > lat_u}, 32'd1);
        check("contend_ram1", {24'd0, ram[1]}, 32'h33);

        // Host write at the current pointer (ptr=2) refreshes the cache.
        @(negedge clk);
        check("ptr_before_hw", {29'd0, ptr}, 32'd2);
        exp_mem[2] = 8'h5A;
        host_op(1'b1, 3'd2, 8'h5A, 8'h00, 1'b0, 8'h00, lat_u);
        check("hw_vld_drop", {31'd0, vld_at_ack}, 32'd0);
        wait_vld(3, ok);
        check("hw_vld_back", {31'd0, ok}, 32'd1);
        check("hw_rdat", {24'd0, i2c_rdat}, 32'h5A);
        check("hw_vld_delay", {31'd0, (vld_rise_cyc - ack_cyc) <= 3}, 32'd1);

        // as and ws together: ws is dropped, next ws sets the index.
        strobe(1'b0, 1'b0, 1'b1, 8'h00);
        w0 = wr_cnt;
        strobe(1'b1, 1'b1, 1'b0, 8'h99);
        @(negedge clk);
        check("asws_no_write", wr_cnt - w0, 32'd0);
        check("asws_ptr", {29'd0, ptr}, 32'd3);
        strobe(1'b0, 1'b1, 1'b0, 8'h0A);
        @(negedge clk);
        check("idx_ptr", {29'd0, ptr}, 32'd2);
        check("idx_no_write", wr_cnt - w0, 32'd0);

        // Reset while a host read is waiting for RAM data.
        @(posedge clk); #1;
        a0 = ack_cnt;
        hbus.host_req = 1'b1; hbus.host_we = 1'b0; hbus.host_addr = 3'd7;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_en && !mem_we && mem_addr == 3'd7) begin
                found = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        check("mid_rd_grant", {31'd0, found}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        hbus.host_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_ack", {31'd0, hbus.host_ack}, 32'd0);
        check("mid_rst_vld", {31'd0, i2c_rdat_vld}, 32'd0);
        check("mid_rst_rdat", {24'd0, i2c_rdat}, 32'd0);
        check("mid_rst_hrdat", {24'd0, hbus.host_rdat}, 32'd0);
        check("mid_rst_ptr", {29'd0, ptr}, 32'd0);
        check("mid_rst_mem_en", {31'd0, mem_en}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        wait_vld(4, ok);
        check("post_rst_vld", {31'd0, ok}, 32'd1);
        check("post_rst_rdat", {24'd0, i2c_rdat}, 32'hA5);
        repeat (6) @(posedge clk);
        #1;
        check("post_rst_no_ack", ack_cnt - a0, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

endmodule
